// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock counters: mode encoding,
// active-low 7-segment digit patterns and the binary-to-BCD digit split.
package clock_pkg;

  localparam logic MODE_RUN = 1'b0;
  localparam logic MODE_SET = 1'b1;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Splits a 0..63 value into its decimal tens and units digits.
  function automatic bcd_t bcd_split(input logic [5:0] value);
    bcd_t r;
    r.tens  = 4'(value / 6'd10);
    r.units = 4'(value % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Push-button front end: two-flop synchronizer plus falling-edge detector
// for an active-low asynchronous button, producing a one-cycle press strobe.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] vld;
  logic       armed;

  // vld marks when sync2 holds a real post-reset sample; armed requires one
  // released sample so a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, matching real hardware.
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      prev  <= sync2;
      vld   <= {vld[0], 1'b1};
      if (vld[1] && sync2) begin
        armed <= 1'b1;
      end
    end
  end

  assign press = armed & ~sync2 & prev;

endmodule

// File: rtl/seg7_decoder.sv
// Single-digit decoder: 4-bit digit to active-low 7-segment pattern.
// Shared by the second, minute and hour counters.
module seg7_decoder
  import clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every path assigns seg (default arm included), so no latch is inferred.
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/second_counter.sv
// Seconds digit-pair counter: counts 00..59 on a prescaled tick in run mode,
// steps from push-buttons in set mode, and emits a carry on run-mode rollover.
module second_counter
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int MODULUS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        add,
  input  logic        deduct,
  output logic [13:0] seg,
  output logic        trigger
);

  localparam int             PRE_W      = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [5:0]     COUNT_LAST = 6'(MODULUS - 1);

  logic [PRE_W-1:0] prescaler;
  logic [5:0]       count;
  logic [5:0]       count_up;
  logic [5:0]       count_down;
  logic             tick;
  logic             add_press;
  logic             deduct_press;
  bcd_t             digits;
  logic [6:0]       tens_seg;
  logic [6:0]       units_seg;

  btn_edge u_add_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (add),
    .press (add_press)
  );

  btn_edge u_deduct_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (deduct),
    .press (deduct_press)
  );

  assign tick       = (mode == MODE_RUN) && (prescaler == PRE_LAST);
  assign count_up   = (count == COUNT_LAST) ? 6'd0 : count + 6'd1;
  assign count_down = (count == 6'd0) ? COUNT_LAST : count - 6'd1;

  // Set mode parks the prescaler at 0, so returning to run always
  // yields a full CLK_DIV-cycle interval before the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      count     <= 6'd0;
      trigger   <= 1'b0;
    end else begin
      trigger <= 1'b0;
      if (mode == MODE_SET) begin
        prescaler <= '0;
        case ({add_press, deduct_press})
          2'b10:   count <= count_up;
          2'b01:   count <= count_down;
          default: count <= count;
        endcase
      end else if (tick) begin
        prescaler <= '0;
        count     <= count_up;
        trigger   <= (count == COUNT_LAST);
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  assign digits = bcd_split(count);

  seg7_decoder u_tens (
    .digit (digits.tens),
    .seg   (tens_seg)
  );

  seg7_decoder u_units (
    .digit (digits.units),
    .seg   (units_seg)
  );

  assign seg = {tens_seg, units_seg};

endmodule

// File: tb/tb_second_counter.sv
// Scoreboard bench for second_counter: the driver pushes per-cycle expectations
// from a cycle-history reference model; a negedge monitor pops and compares.
module tb_second_counter;

  localparam int CLK_DIV = 4;
  localparam int MAXC    = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        add;
  logic        deduct;
  logic [13:0] seg;
  logic        trigger;

  second_counter #(
    .CLK_DIV (CLK_DIV),
    .MODULUS (60)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .add     (add),
    .deduct  (deduct),
    .seg     (seg),
    .trigger (trigger)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   secs;
    logic trig;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: seconds value, run streak, and input history.
  int   secs   = 0;
  int   streak = 0;
  logic h_rst [MAXC];
  logic h_add [MAXC];
  logic h_ded [MAXC];

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] exp_seg(input int s);
    return {pat[s / 10], pat[s % 10]};
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0b, expected %0b", name, cyc, actual, expected);
    end
  endtask

  // No reset at any edge between the high sample and the step edge.
  function automatic bit clean(input int k);
    for (int j = k - 3; j <= k; j++) begin
      if (h_rst[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drives one cycle of inputs, predicts the state after the next edge,
  // pushes that expectation, and advances to just after that edge.
  task automatic drive(input logic r, input logic m, input logic a, input logic d);
    int   k;
    bit   pa;
    bit   pd;
    exp_t e;
    k = cyc;
    if (k >= MAXC) begin
      $display("FAIL history_overflow: cycle %0d, limit %0d", k, MAXC);
      $fatal(1);
    end
    rst = r; mode = m; add = a; deduct = d;
    h_rst[k] = r; h_add[k] = a; h_ded[k] = d;
    e.trig = 1'b0;
    if (r) begin
      secs   = 0;
      streak = 0;
    end else if (m) begin
      streak = 0;
      // A press takes effect two edges after the first low sample.
      pa = (k >= 3) && clean(k) && (h_add[k-2] == 1'b0) && (h_add[k-3] == 1'b1);
      pd = (k >= 3) && clean(k) && (h_ded[k-2] == 1'b0) && (h_ded[k-3] == 1'b1);
      if (pa && !pd) secs = (secs + 1) % 60;
      else if (pd && !pa) secs = (secs + 59) % 60;
    end else begin
      streak++;
      if (streak % CLK_DIV == 0) begin
        e.trig = (secs == 59);
        secs   = (secs + 1) % 60;
      end
    end
    e.cyc  = k + 1;
    e.secs = secs;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic repeat_drive(input int n, input logic r, input logic m,
                              input logic a, input logic d);
    for (int i = 0; i < n; i++) drive(r, m, a, d);
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check("seg", int'(seg), int'(exp_seg(mon_e.secs)));
      check("trigger", int'(trigger), int'(mon_e.trig));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   s0;
    logic m;
    logic a;
    logic d;
    int   ha;
    int   hd;

    // Reset with buttons released.
    repeat_drive(2, 1'b1, 1'b0, 1'b1, 1'b1);
    check("reset_seg", int'(seg), int'(14'b1000000_1000000));
    check("reset_trigger", int'(trigger), 0);

    // 240 run cycles: 60 ticks, ending on the 59->00 wrap with a carry.
    repeat_drive(240, 1'b0, 1'b0, 1'b1, 1'b1);
    check("wrap_trigger", int'(trigger), 1);
    check("wrap_seg", int'(seg), int'(14'b1000000_1000000));

    // Set mode: deduct 0->59, then hold add 10 cycles for 59->0.
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat_drive(4, 1'b0, 1'b1, 1'b1, 1'b1);
    check("set_down_59", int'(seg), int'(14'b0010010_0010000));
    repeat_drive(10, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat_drive(4, 1'b0, 1'b1, 1'b1, 1'b1);
    check("set_up_00", int'(seg), int'(14'b1000000_1000000));
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b1);
    check("set_down_58", int'(seg), int'(14'b0010010_0000000));

    // Both buttons fall together: no change.
    repeat_drive(4, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat_drive(4, 1'b0, 1'b1, 1'b1, 1'b1);
    check("both_pressed", int'(seg), int'(14'b0010010_0000000));

    // Presses in run mode are ignored beyond normal ticks.
    repeat_drive(3, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat_drive(3, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat_drive(3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat_drive(3, 1'b0, 1'b0, 1'b1, 1'b1);

    // Mode switch mid-prescale: next increment exactly CLK_DIV cycles after return.
    repeat_drive(2, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat_drive(2, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat_drive(5, 1'b0, 1'b1, 1'b1, 1'b1);
    s0 = secs;
    repeat_drive(CLK_DIV - 1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("resume_hold", int'(seg), int'(exp_seg(s0)));
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("resume_step", int'(seg), int'(exp_seg((s0 + 1) % 60)));

    // Reset mid-press: a held button gives no step until released and re-pressed.
    repeat_drive(2, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat_drive(2, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat_drive(6, 1'b0, 1'b1, 1'b0, 1'b1);
    check("reset_held_no_step", int'(seg), int'(14'b1000000_1000000));
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat_drive(3, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat_drive(2, 1'b0, 1'b1, 1'b1, 1'b1);
    check("repress_step", int'(seg), int'(exp_seg(1)));

    // Randomized mix of modes, button holds and occasional resets.
    m = 1'b0; a = 1'b1; d = 1'b1; ha = 0; hd = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(39) == 0) m = ~m;
      if (ha == 0) begin
        a  = 1'($urandom_range(1));
        ha = $urandom_range(8, 1);
      end
      ha--;
      if (hd == 0) begin
        d  = 1'($urandom_range(1));
        hd = $urandom_range(8, 1);
      end
      hd--;
      drive(($urandom_range(299) == 0) ? 1'b1 : 1'b0, m, a, d);
    end
    repeat_drive(3, 1'b0, 1'b1, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
